// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Types and constants shared by the FFT core and its output buffer.
//   FFT_N / DATA_W   : frame length and sample component width
//   sample_t         : complex sample word {re[31:16], im[15:0]}; the core's
//                      write data uses this same layout
//   tagged_sample_t  : sample plus an end-of-frame marker, as held in the FIFO
//   xfer()           : handshake rule; a word moves when push && !stall
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_N  = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } sample_t;

    typedef struct packed {
        logic    last;
        sample_t s;
    } tagged_sample_t;

    function automatic logic xfer(input logic push, input logic stall);
        return push && !stall;
    endfunction

endpackage

// File: rtl/fft_sync_fifo.sv
// ---------------------------------------------------------------------------
// fft_sync_fifo
// Generic single-clock FIFO with first-word-fall-through read.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-low; clears pointers/level, not the array
//   wr_en_i    : write wr_data_i at the write pointer (caller ensures not full)
//   wr_data_i  : word to store
//   rd_en_i    : advance the read pointer (caller ensures not empty)
//   rd_data_o  : head word; reads as zero while empty
//   level_o    : current occupancy, 0..DEPTH
//   full_o     : registered, high while level == DEPTH
// ---------------------------------------------------------------------------
module fft_sync_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          full_q,   full_d;

    // Pointers are exactly AW bits wide so they wrap on their own; occupancy
    // is tracked separately so full and empty are never ambiguous.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
        rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
        level_d  = level_q + LW'(wr_en_i) - LW'(rd_en_i);
        full_d   = (level_d == LW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // The head is read asynchronously so a word written at one edge is
    // visible right after it. Masking with the level keeps the outputs at
    // zero while empty, including straight after reset.
    assign rd_data_o = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign level_o   = level_q;
    assign full_o    = full_q;

endmodule

// File: rtl/fft_out_buffer.sv
// ---------------------------------------------------------------------------
// fft_out_buffer
// Elastic buffer behind the FFT core. The core streams a frame without
// looking at in_stall, so this block absorbs consumer backpressure, tags the
// final sample of each frame and drops (and flags) samples arriving while full.
// Ports:
//   clk, reset             : clock; synchronous active-low reset
//   in_push/in_real/in_imag: upstream sample and valid
//   in_stall               : registered, high while the buffer is full
//   out_push               : head sample valid
//   out_real/out_imag      : head sample
//   out_last               : head sample is the last of its frame
//   out_stall              : consumer cannot accept this cycle
//   overflow               : sticky, a sample has been dropped since reset
//   level                  : occupancy
//   frame_count            : frames fully delivered, wrapping
// ---------------------------------------------------------------------------
module fft_out_buffer
    import fft_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int FRAME_LEN = FFT_N,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_push,
    input  logic [DATA_W-1:0]      in_real,
    input  logic [DATA_W-1:0]      in_imag,
    output logic                   in_stall,
    output logic                   out_push,
    output logic [DATA_W-1:0]      out_real,
    output logic [DATA_W-1:0]      out_imag,
    output logic                   out_last,
    input  logic                   out_stall,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       frame_count
);

    localparam int IW = $clog2(FRAME_LEN);
    localparam int LW = $clog2(DEPTH) + 1;

    tagged_sample_t wr_word;
    tagged_sample_t head;
    logic           head_valid;
    logic           accept;
    logic           pop;

    logic [IW-1:0]    in_idx_q,      in_idx_d;
    logic             overflow_q,    overflow_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;

    fft_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(tagged_sample_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (accept),
        .wr_data_i (wr_word),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .level_o   (level),
        .full_o    (in_stall)
    );

    always_comb begin
        head_valid = (level != '0);
        // Acceptance looks only at the pre-edge level: a pop in the same
        // cycle as a full buffer does not make room for the incoming sample.
        accept     = in_push && (level < LW'(DEPTH));
        pop        = xfer(head_valid, out_stall);

        wr_word.last = (in_idx_q == IW'(FRAME_LEN - 1));
        wr_word.s.re = in_real;
        wr_word.s.im = in_imag;

        // The frame index advances on dropped samples too, so the core's
        // frame boundaries stay aligned after an overflow.
        in_idx_d      = in_push ? in_idx_q + IW'(1) : in_idx_q;
        overflow_d    = overflow_q | (in_push & ~accept);
        frame_count_d = frame_count_q + CNT_W'(pop && head.last);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_idx_q      <= '0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            in_idx_q      <= in_idx_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign out_push    = head_valid;
    assign out_real    = head.s.re;
    assign out_imag    = head.s.im;
    assign out_last    = head.last;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule
